// File: rtl/axi_slave_write.sv
// AXI4 write-channel responder: one burst at a time, W beats drive a byte-strobed memory port,
// one B response per burst.
module axi_slave_write #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = 'h10000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          AW_VALID,
  output logic                          AW_READY,
  input  logic [2:0]                    AW_PROT,
  input  logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  input  logic [7:0]                    AW_LEN,
  input  logic [2:0]                    AW_SIZE,
  input  logic [1:0]                    AW_BURST,
  input  logic                          W_VALID,
  output logic                          W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  input  logic                          W_LAST,
  output logic                          B_VALID,
  input  logic                          B_READY,
  output logic [1:0]                    B_RESP,
  output logic                          o_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0]     o_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]     o_wr_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wr_strb,
  input  logic                          i_wr_ready
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] MaxSize = 3'($clog2(StrbW));

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e     state_q;
  logic       aw_ready_q, b_valid_q;
  logic [1:0] b_resp_q;
  addr_t      addr_q;
  logic [7:0] len_q, cnt_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic       dec_err_q, slv_err_q, last_err_q;

  logic  aw_hs, beat, last_beat, last_bad;
  logic  aw_dec_err, aw_slv_err;
  addr_t aw_off, aw_bytes, step, wrap_mask, addr_nxt;
  logic  unused_prot;

  assign unused_prot = ^AW_PROT;

  assign AW_READY = aw_ready_q & ~rst;
  assign W_READY  = (state_q == StData) & i_wr_ready & ~rst;
  assign B_VALID  = b_valid_q & ~rst;
  assign B_RESP   = rst ? 2'b00 : b_resp_q;

  assign aw_hs     = AW_VALID & AW_READY;
  assign beat      = W_VALID & W_READY;
  assign last_beat = (cnt_q == len_q);
  assign last_bad  = (W_LAST != last_beat);

  assign o_wr_en   = beat & ~dec_err_q & ~slv_err_q;
  assign o_wr_addr = addr_q & ~addr_t'(StrbW - 1);
  assign o_wr_data = W_DATA;
  assign o_wr_strb = W_STRB;

  // Only INCR bursts are checked for running off the top of the window.
  assign aw_off     = AW_ADDR - BASE_ADDR;
  assign aw_bytes   = (addr_t'(AW_LEN) + addr_t'(1)) << AW_SIZE;
  assign aw_dec_err = (AW_ADDR < BASE_ADDR) | (aw_off >= MEM_BYTES) |
                      ((AW_BURST == 2'b01) & (aw_off + aw_bytes > MEM_BYTES));
  assign aw_slv_err = (AW_BURST == 2'b11) | (AW_SIZE > MaxSize) |
                      ((AW_BURST == 2'b10) & !(AW_LEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

  assign step      = addr_t'(1) << size_q;
  assign wrap_mask = ((addr_t'(len_q) + addr_t'(1)) << size_q) - addr_t'(1);

  always_comb begin
    addr_nxt = addr_q + step;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      dec_err_q  <= 1'b0;
      slv_err_q  <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          aw_ready_q <= ~aw_hs;
          if (aw_hs) begin
            state_q    <= StData;
            addr_q     <= AW_ADDR;
            len_q      <= AW_LEN;
            size_q     <= AW_SIZE;
            burst_q    <= AW_BURST;
            cnt_q      <= '0;
            dec_err_q  <= aw_dec_err;
            slv_err_q  <= aw_slv_err;
            last_err_q <= 1'b0;
          end
        end
        StData: begin
          if (beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_nxt;
            if (last_bad) last_err_q <= 1'b1;
            // Burst length comes from AW_LEN alone; W_LAST only affects the response code.
            if (last_beat) begin
              state_q   <= StResp;
              b_valid_q <= 1'b1;
              if (dec_err_q)                              b_resp_q <= 2'b11;
              else if (slv_err_q | last_err_q | last_bad) b_resp_q <= 2'b10;
              else                                        b_resp_q <= 2'b00;
            end
          end
        end
        StResp: begin
          if (B_READY) begin
            state_q    <= StIdle;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_write.sv
// Randomized bench for axi_slave_write with a burst-level reference model and directed cases.
module tb_axi_slave_write;

  localparam logic [63:0] Base = 64'h0;
  localparam logic [63:0] Mem  = 64'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        AW_VALID, AW_READY;
  logic [2:0]  AW_PROT;
  logic [63:0] AW_ADDR;
  logic [7:0]  AW_LEN;
  logic [2:0]  AW_SIZE;
  logic [1:0]  AW_BURST;
  logic        W_VALID, W_READY, W_LAST;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        o_wr_en;
  logic [63:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_strb;
  logic        i_wr_ready;

  always #5 clk = ~clk;

  axi_slave_write dut (
    .clk(clk), .rst(rst),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_PROT(AW_PROT), .AW_ADDR(AW_ADDR),
    .AW_LEN(AW_LEN), .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_strb(o_wr_strb),
    .i_wr_ready(i_wr_ready)
  );

  typedef struct packed {logic [63:0] a; logic [31:0] d; logic [3:0] s;} wr_t;

  wr_t         exp_q[$];
  logic [1:0]  resp_q[$];
  logic [63:0] obs_addr[$];
  logic [1:0]  obs_resp;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout/unexpected required=handshake/expected-event", name);
  endtask

  // Byte address of beat i, word-aligned, straight from the burst definitions.
  function automatic logic [63:0] beat_addr(input logic [63:0] a, input int len, input int size,
                                            input int burst, input int i);
    logic [63:0] step, bs, lo, r;
    step = 64'd1 << size;
    bs   = 64'(len + 1) * step;
    case (burst)
      1: r = a + 64'(i) * step;
      2: begin
        lo = a - (a % bs);
        r  = lo + ((a - lo + 64'(i) * step) % bs);
      end
      default: r = a;
    endcase
    return r & ~64'h3;
  endfunction

  function automatic bit model_dec(input logic [63:0] a, input int len, input int size,
                                   input int burst);
    logic [63:0] bytes;
    bytes = 64'(len + 1) << size;
    return (a < Base) || (a >= Base + Mem) || (burst == 1 && a + bytes > Base + Mem);
  endfunction

  function automatic bit model_slv(input int len, input int size, input int burst);
    return (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (o_wr_en) begin
        obs_addr.push_back(o_wr_addr);
        check("wr_en_handshake", {62'd0, W_VALID, i_wr_ready}, 64'd3);
        if (exp_q.size() == 0) fail("stray_write");
        else begin
          e = exp_q.pop_front();
          check("wr_addr", o_wr_addr, e.a);
          check("wr_data", o_wr_data, e.d);
          check("wr_strb", o_wr_strb, e.s);
        end
      end
      if (B_VALID && B_READY) begin
        obs_resp = B_RESP;
        if (resp_q.size() == 0) fail("stray_b");
        else check("b_resp", B_RESP, resp_q.pop_front());
      end
    end
  end

  task automatic run_burst(input logic [63:0] a, input int len, input int size, input int burst,
                           input int bad_beat, input int stall_beat, input int stall_pct,
                           input int bwait);
    logic [31:0] d[$];
    logic [3:0]  s[$];
    bit dec, slv, lastbad, hs;
    int cyc, i, stalls;
    for (int k = 0; k <= len; k++) begin
      d.push_back($urandom);
      s.push_back(4'($urandom));
    end
    lastbad = (bad_beat >= 0) && (bad_beat <= len);
    dec = model_dec(a, len, size, burst);
    slv = model_slv(len, size, burst);
    if (!dec && !slv)
      for (int k = 0; k <= len; k++) exp_q.push_back('{beat_addr(a, len, size, burst, k), d[k], s[k]});
    resp_q.push_back(dec ? 2'b11 : (slv || lastbad) ? 2'b10 : 2'b00);

    AW_VALID = 1'b1; AW_ADDR = a; AW_LEN = 8'(len); AW_SIZE = 3'(size); AW_BURST = 2'(burst);
    AW_PROT = 3'($urandom);
    cyc = 0;
    do begin
      @(negedge clk); hs = AW_VALID && AW_READY;
      @(posedge clk); #1; cyc++;
    end while (!hs && cyc < 50);
    AW_VALID = 1'b0;
    if (!hs) begin fail("aw_timeout"); return; end

    i = 0; cyc = 0; stalls = 0;
    while (i <= len && cyc < 2000) begin
      W_VALID = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(stall_pct / 2));
      W_DATA = d[i]; W_STRB = s[i];
      W_LAST = (i == len) ^ (i == bad_beat);
      if (i == stall_beat && stalls < 3) begin
        i_wr_ready = 1'b0; stalls++;
      end else i_wr_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
      @(negedge clk); hs = W_VALID && W_READY;
      if (!i_wr_ready) check("w_ready_stalled", {63'd0, W_READY}, 64'd0);
      @(posedge clk); #1; cyc++;
      if (hs) i++;
    end
    W_VALID = 1'b0; W_LAST = 1'b0; i_wr_ready = 1'b1;
    if (i <= len) begin fail("w_timeout"); return; end
    if (bwait < 0) return;

    B_READY = 1'b0;
    repeat (bwait) begin @(posedge clk); #1; end
    B_READY = 1'b1; cyc = 0;
    do begin
      @(negedge clk); hs = B_VALID && B_READY;
      @(posedge clk); #1; cyc++;
    end while (!hs && cyc < 50);
    B_READY = 1'b0;
    if (!hs) fail("b_timeout");
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, size, burst, bb;
    logic [63:0] a;
    rst = 1'b1; AW_VALID = 0; AW_PROT = 0; AW_ADDR = 0; AW_LEN = 0; AW_SIZE = 0; AW_BURST = 0;
    W_VALID = 0; W_DATA = 0; W_STRB = 0; W_LAST = 0; B_READY = 0; i_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_aw_ready", {63'd0, AW_READY}, 64'd0);
    check("rst_w_ready", {63'd0, W_READY}, 64'd0);
    check("rst_b_valid", {63'd0, B_VALID}, 64'd0);
    check("rst_wr_en", {63'd0, o_wr_en}, 64'd0);
    check("rst_b_resp", {62'd0, B_RESP}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("aw_ready_idle", {63'd0, AW_READY}, 64'd1);
    @(posedge clk); #1;

    // 1: single beat latency
    exp_q.push_back('{64'h100, 32'hDEADBEEF, 4'hF});
    resp_q.push_back(2'b00);
    AW_VALID = 1; AW_ADDR = 64'h100; AW_LEN = 0; AW_SIZE = 2; AW_BURST = 1;
    W_VALID = 1; W_DATA = 32'hDEADBEEF; W_STRB = 4'hF; W_LAST = 1; i_wr_ready = 1; B_READY = 1;
    @(negedge clk);
    check("t1_aw_ready", {63'd0, AW_READY}, 64'd1);
    check("t1_no_early_write", {63'd0, o_wr_en}, 64'd0);
    @(posedge clk); #1; AW_VALID = 0;
    @(negedge clk);
    check("t1_wr_en_n1", {63'd0, o_wr_en}, 64'd1);
    check("t1_wr_addr", o_wr_addr, 64'h100);
    @(posedge clk); #1; W_VALID = 0; W_LAST = 0;
    @(negedge clk);
    check("t1_b_valid_n2", {63'd0, B_VALID}, 64'd1);
    check("t1_b_resp", {62'd0, B_RESP}, 64'd0);
    @(posedge clk); #1; B_READY = 0;

    // 2: INCR with a stall on beat 2
    obs_addr.delete();
    run_burst(64'h200, 3, 2, 1, -1, 2, 0, 1);
    check("t2_count", 64'(obs_addr.size()), 64'd4);
    if (obs_addr.size() == 4) begin
      check("t2_a0", obs_addr[0], 64'h200); check("t2_a1", obs_addr[1], 64'h204);
      check("t2_a2", obs_addr[2], 64'h208); check("t2_a3", obs_addr[3], 64'h20C);
    end

    // 3: WRAP
    obs_addr.delete();
    run_burst(64'h108, 3, 2, 2, -1, -1, 0, 0);
    check("t3_count", 64'(obs_addr.size()), 64'd4);
    if (obs_addr.size() == 4) begin
      check("t3_a0", obs_addr[0], 64'h108); check("t3_a1", obs_addr[1], 64'h10C);
      check("t3_a2", obs_addr[2], 64'h100); check("t3_a3", obs_addr[3], 64'h104);
    end
    check("t3_resp", {62'd0, obs_resp}, 64'd0);

    // 4: outside the window
    obs_addr.delete();
    run_burst(Base + Mem, 1, 2, 1, -1, -1, 20, 2);
    check("t4_no_writes", 64'(obs_addr.size()), 64'd0);
    check("t4_resp", {62'd0, obs_resp}, 64'd3);

    // 5: early W_LAST
    obs_addr.delete();
    run_burst(64'h400, 2, 2, 1, 1, -1, 0, 0);
    check("t5_writes", 64'(obs_addr.size()), 64'd3);
    check("t5_resp", {62'd0, obs_resp}, 64'd2);

    // 6: B held, then reset
    run_burst(64'h300, 0, 2, 1, -1, -1, 0, -1);
    repeat (5) begin
      @(negedge clk);
      check("t6_b_hold_valid", {63'd0, B_VALID}, 64'd1);
      check("t6_b_hold_resp", {62'd0, B_RESP}, 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_b_valid", {63'd0, B_VALID}, 64'd0);
    check("t6_rst_aw_ready", {63'd0, AW_READY}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    resp_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_aw_ready_after_rst", {63'd0, AW_READY}, 64'd1);
    check("t6_b_valid_after_rst", {63'd0, B_VALID}, 64'd0);
    @(posedge clk); #1;

    // Random bursts
    for (int n = 0; n < 60; n++) begin
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = int'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: a = Base + Mem - 64'($urandom_range(1, 64));
        1: a = Base + Mem + 64'($urandom_range(0, 255));
        default: a = Base + 64'($urandom_range(0, 32'hFFFF));
      endcase
      a = a & ~((64'd1 << size) - 64'd1);
      bb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(a, len, size, burst, bb, -1, int'($urandom_range(0, 60)),
                int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
